// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: state encoding and default chain length shared by the shift chain controller
package shift_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam int DEF_WIDTH = 2;
endpackage

// File: rtl/shift_bit_cnt.sv
// shift_bit_cnt: bit counter for one serial transaction, flags the final bit
module shift_bit_cnt
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic C,
  input  logic R,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge C or posedge R)
    if (R) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign last = cnt == CNT_W'(WIDTH - 1);
endmodule

// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: swaps a parallel word into a serial dff chain, MSB first,
// while capturing the old chain contents falling out of the tail
module shift_chain_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sd,
  output logic             se,
  input  logic             sq,
  output logic [WIDTH-1:0] dout,
  output logic             done
);
  state_t state;
  logic [WIDTH-1:0] shadow, shifted;
  logic last;
  // shift form that stays legal for a single-stage chain
  assign shifted = (shadow << 1) | WIDTH'(sq);
  assign sd = se & shadow[WIDTH-1];
  shift_bit_cnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .C    (C),
    .R    (R),
    .clr  (state == ST_IDLE),
    .en   (state == ST_SHIFT),
    .last (last)
  );
  always_ff @(posedge C or posedge R)
    if (R) begin
      state  <= ST_IDLE;
      ready  <= 1'b1;
      se     <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
      shadow <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          shadow <= din;
          state  <= ST_SHIFT;
          ready  <= 1'b0;
          se     <= 1'b1;
        end
        ST_SHIFT: begin
          shadow <= shifted;
          if (last) begin
            dout  <= shifted;
            state <= ST_DONE;
            se    <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          se    <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
endmodule
